// File: rtl/regfile_rename_mp_pkg.sv
// Shared defaults and index-width helper for the register file / rename table.
package regfile_rename_mp_pkg;

  localparam int XLEN_DEF        = 32;
  localparam int NUM_REGS_DEF    = 32;
  localparam int ROB_WIDTH_DEF   = 4;
  localparam int READ_PORTS_DEF  = 2;
  localparam int COMMIT_WAYS_DEF = 2;

  // Width of an index into n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_bypass_sel.sv
// One read port: architectural lookup result merged with a same-cycle commit bypass.
module regfile_bypass_sel #(
  parameter int XLEN        = 32,
  parameter int REG_W       = 5,
  parameter int ROB_WIDTH   = 4,
  parameter int COMMIT_WAYS = 2
) (
  input  logic [REG_W-1:0]                   rd_id,
  input  logic                               reg_busy,
  input  logic [ROB_WIDTH-1:0]               reg_tag,
  input  logic [XLEN-1:0]                    reg_val,
  input  logic [COMMIT_WAYS-1:0]             cm_valid,
  input  logic [COMMIT_WAYS*REG_W-1:0]       cm_rd,
  input  logic [COMMIT_WAYS*ROB_WIDTH-1:0]   cm_tag,
  input  logic [COMMIT_WAYS*XLEN-1:0]        cm_val,
  output logic                               busy,
  output logic [ROB_WIDTH-1:0]               tag,
  output logic [XLEN-1:0]                    val
);

  logic hit;

  always_comb begin
    hit  = 1'b0;
    busy = reg_busy;
    tag  = reg_tag;
    val  = reg_val;
    // Ascending scan so the youngest matching way is the last to write val.
    for (int w = 0; w < COMMIT_WAYS; w++) begin
      if (reg_busy && cm_valid[w] &&
          (cm_rd[w*REG_W +: REG_W] == rd_id) &&
          (cm_tag[w*ROB_WIDTH +: ROB_WIDTH] == reg_tag)) begin
        hit = 1'b1;
        val = cm_val[w*XLEN +: XLEN];
      end
    end
    if (hit) begin
      busy = 1'b0;
    end
    if (rd_id == '0) begin
      busy = 1'b0;
      tag  = '0;
      val  = '0;
    end
  end

endmodule

// File: rtl/regfile_rename_mp.sv
// Architectural register file plus busy/tag rename table with multi-port reads,
// multi-way commit and flush.
module regfile_rename_mp
  import regfile_rename_mp_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int ROB_WIDTH   = ROB_WIDTH_DEF,
  parameter int READ_PORTS  = READ_PORTS_DEF,
  parameter int COMMIT_WAYS = COMMIT_WAYS_DEF,
  parameter int REG_W       = idx_w(NUM_REGS)
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               rdy_in,
  input  logic                               clr_in,
  input  logic                               issue_valid,
  input  logic [REG_W-1:0]                   issue_rd,
  input  logic [ROB_WIDTH-1:0]               issue_tag,
  input  logic [READ_PORTS*REG_W-1:0]        rd_id,
  output logic [READ_PORTS-1:0]              rd_busy,
  output logic [READ_PORTS*ROB_WIDTH-1:0]    rd_tag,
  output logic [READ_PORTS*XLEN-1:0]         rd_val,
  input  logic [COMMIT_WAYS-1:0]             cm_valid,
  input  logic [COMMIT_WAYS*REG_W-1:0]       cm_rd,
  input  logic [COMMIT_WAYS*ROB_WIDTH-1:0]   cm_tag,
  input  logic [COMMIT_WAYS*XLEN-1:0]        cm_val
);

  logic [XLEN-1:0]      val_q [NUM_REGS];
  logic [ROB_WIDTH-1:0] tag_q [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_q;

  logic [XLEN-1:0]      val_d [NUM_REGS];
  logic [ROB_WIDTH-1:0] tag_d [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_d;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [REG_W-1:0] r;
    assign r = rd_id[p*REG_W +: REG_W];

    regfile_bypass_sel #(
      .XLEN        (XLEN),
      .REG_W       (REG_W),
      .ROB_WIDTH   (ROB_WIDTH),
      .COMMIT_WAYS (COMMIT_WAYS)
    ) u_sel (
      .rd_id    (r),
      .reg_busy (busy_q[r]),
      .reg_tag  (tag_q[r]),
      .reg_val  (val_q[r]),
      .cm_valid (cm_valid),
      .cm_rd    (cm_rd),
      .cm_tag   (cm_tag),
      .cm_val   (cm_val),
      .busy     (rd_busy[p]),
      .tag      (rd_tag[p*ROB_WIDTH +: ROB_WIDTH]),
      .val      (rd_val[p*XLEN +: XLEN])
    );
  end

  // Commits first (higher way overwrites), then flush or issue layered on top.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    for (int w = 0; w < COMMIT_WAYS; w++) begin
      if (cm_valid[w] && (cm_rd[w*REG_W +: REG_W] != '0)) begin
        val_d[cm_rd[w*REG_W +: REG_W]] = cm_val[w*XLEN +: XLEN];
        if (tag_q[cm_rd[w*REG_W +: REG_W]] == cm_tag[w*ROB_WIDTH +: ROB_WIDTH]) begin
          busy_d[cm_rd[w*REG_W +: REG_W]] = 1'b0;
        end
      end
    end
    if (clr_in) begin
      busy_d = '0;
    end else if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
      tag_d[issue_rd]  = issue_tag;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (rdy_in) begin
      busy_q <= busy_d;
      val_q  <= val_d;
      tag_q  <= tag_d;
    end
  end

endmodule

// File: tb/tb_regfile_rename_mp.sv
// Scoreboard bench for regfile_rename_mp: expected read-port results are queued
// with each stimulus cycle and compared mid-cycle.
module tb_regfile_rename_mp;

  localparam int XLEN = 32;
  localparam int REG_W = 5;
  localparam int ROB_WIDTH = 4;
  localparam int READ_PORTS = 2;
  localparam int COMMIT_WAYS = 2;

  logic                             clk_in = 1'b0;
  logic                             rst_in;
  logic                             rdy_in;
  logic                             clr_in;
  logic                             issue_valid;
  logic [REG_W-1:0]                 issue_rd;
  logic [ROB_WIDTH-1:0]             issue_tag;
  logic [READ_PORTS*REG_W-1:0]      rd_id;
  logic [READ_PORTS-1:0]            rd_busy;
  logic [READ_PORTS*ROB_WIDTH-1:0]  rd_tag;
  logic [READ_PORTS*XLEN-1:0]       rd_val;
  logic [COMMIT_WAYS-1:0]           cm_valid;
  logic [COMMIT_WAYS*REG_W-1:0]     cm_rd;
  logic [COMMIT_WAYS*ROB_WIDTH-1:0] cm_tag;
  logic [COMMIT_WAYS*XLEN-1:0]      cm_val;

  regfile_rename_mp dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .clr_in      (clr_in),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_tag   (issue_tag),
    .rd_id       (rd_id),
    .rd_busy     (rd_busy),
    .rd_tag      (rd_tag),
    .rd_val      (rd_val),
    .cm_valid    (cm_valid),
    .cm_rd       (cm_rd),
    .cm_tag      (cm_tag),
    .cm_val      (cm_val)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string          nm;
    int             port;
    logic           busy;
    logic           chk_tag;
    logic [3:0]     tag;
    logic [31:0]    val;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, obs, exp);
    end
  endtask

  task automatic idle();
    clr_in      = 1'b0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    issue_tag   = '0;
    cm_valid    = '0;
    cm_rd       = '0;
    cm_tag      = '0;
    cm_val      = '0;
  endtask

  task automatic rd(input int p, input int r);
    rd_id[p*REG_W +: REG_W] = REG_W'(r);
  endtask

  task automatic iss(input int r, input int t);
    issue_valid = 1'b1;
    issue_rd    = REG_W'(r);
    issue_tag   = ROB_WIDTH'(t);
  endtask

  task automatic cm(input int w, input int r, input int t, input logic [31:0] v);
    cm_valid[w]                       = 1'b1;
    cm_rd[w*REG_W +: REG_W]           = REG_W'(r);
    cm_tag[w*ROB_WIDTH +: ROB_WIDTH]  = ROB_WIDTH'(t);
    cm_val[w*XLEN +: XLEN]            = v;
  endtask

  task automatic expect_rd(input string nm, input int p, input logic busy,
                           input logic chk_tag, input int tag, input logic [31:0] val);
    exp_t e;
    e.nm = nm; e.port = p; e.busy = busy; e.chk_tag = chk_tag;
    e.tag = 4'(tag); e.val = val;
    exp_q.push_back(e);
  endtask

  // Compare queued expectations mid-cycle, then let the edge apply the stimulus.
  task automatic step();
    exp_t e;
    @(negedge clk_in);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.nm, ".busy"}, 64'(rd_busy[e.port]), 64'(e.busy));
      if (e.chk_tag)
        check({e.nm, ".tag"}, 64'(rd_tag[e.port*ROB_WIDTH +: ROB_WIDTH]), 64'(e.tag));
      check({e.nm, ".val"}, 64'(rd_val[e.port*XLEN +: XLEN]), 64'(e.val));
    end
    @(posedge clk_in);
    #1;
    idle();
  endtask

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    rd_id  = '0;
    idle();
    @(posedge clk_in);
    #1;

    // 1: reset state and x0 hardwiring
    rd(0, 5); rd(1, 5);
    expect_rd("rst_p0_x5", 0, 1'b0, 1'b0, 0, 32'h0);
    expect_rd("rst_p1_x5", 1, 1'b0, 1'b0, 0, 32'h0);
    step();
    rst_in = 1'b1;
    cm(0, 0, 0, 32'hDEAD);
    rd(0, 0);
    expect_rd("x0_cm_cycle", 0, 1'b0, 1'b0, 0, 32'h0);
    step();
    rd(0, 0); rd(1, 0);
    expect_rd("x0_after_p0", 0, 1'b0, 1'b0, 0, 32'h0);
    expect_rd("x0_after_p1", 1, 1'b0, 1'b0, 0, 32'h0);
    step();

    // 2: issue, busy lookup, commit bypass, array value
    iss(3, 7);
    rd(0, 3);
    expect_rd("x3_pre_issue", 0, 1'b0, 1'b0, 0, 32'h0);
    step();
    rd(0, 3); rd(1, 3);
    expect_rd("x3_busy_p0", 0, 1'b1, 1'b1, 7, 32'h0);
    expect_rd("x3_busy_p1", 1, 1'b1, 1'b1, 7, 32'h0);
    step();
    cm(0, 3, 7, 32'h55);
    rd(0, 3); rd(1, 3);
    expect_rd("x3_bypass_p0", 0, 1'b0, 1'b0, 0, 32'h55);
    expect_rd("x3_bypass_p1", 1, 1'b0, 1'b0, 0, 32'h55);
    step();
    rd(0, 3);
    expect_rd("x3_array", 0, 1'b0, 1'b0, 0, 32'h55);
    step();

    // 3: stale commit writes value but leaves the newer mapping busy
    iss(4, 2);
    step();
    iss(4, 9);
    step();
    cm(0, 4, 2, 32'h1);
    rd(0, 4);
    expect_rd("x4_stale_nobypass", 0, 1'b1, 1'b1, 9, 32'h0);
    step();
    rd(0, 4);
    expect_rd("x4_after_stale", 0, 1'b1, 1'b1, 9, 32'h1);
    step();

    // 4: issue beats same-cycle commit clear
    iss(6, 3);
    step();
    cm(0, 6, 3, 32'h66);
    iss(6, 5);
    rd(0, 6);
    expect_rd("x6_bypass_preissue", 0, 1'b0, 1'b0, 0, 32'h66);
    step();
    rd(0, 6);
    expect_rd("x6_reissued", 0, 1'b1, 1'b1, 5, 32'h66);
    step();

    // 5: two ways to one register, younger wins
    iss(8, 4);
    step();
    cm(0, 8, 4, 32'hA);
    cm(1, 8, 4, 32'hB);
    rd(1, 8);
    expect_rd("x8_bypass_young", 1, 1'b0, 1'b0, 0, 32'hB);
    step();
    rd(0, 8);
    expect_rd("x8_array_young", 0, 1'b0, 1'b0, 0, 32'hB);
    step();

    // 6: flush held with rdy low, then taken
    iss(1, 10);
    step();
    iss(2, 11);
    step();
    rdy_in = 1'b0;
    clr_in = 1'b1;
    cm(0, 1, 12, 32'h77);
    iss(9, 1);
    rd(0, 1);
    expect_rd("x1_frozen_read", 0, 1'b1, 1'b1, 10, 32'h0);
    step();
    rdy_in = 1'b1;
    rd(0, 1); rd(1, 9);
    expect_rd("x1_after_frozen", 0, 1'b1, 1'b1, 10, 32'h0);
    expect_rd("x9_after_frozen", 1, 1'b0, 1'b0, 0, 32'h0);
    clr_in = 1'b1;
    cm(0, 1, 12, 32'h77);
    iss(9, 1);
    step();
    rd(0, 1); rd(1, 9);
    expect_rd("x1_after_clr", 0, 1'b0, 1'b0, 0, 32'h77);
    expect_rd("x9_after_clr", 1, 1'b0, 1'b0, 0, 32'h0);
    step();
    rd(0, 2); rd(1, 4);
    expect_rd("x2_after_clr", 0, 1'b0, 1'b0, 0, 32'h0);
    expect_rd("x4_after_clr", 1, 1'b0, 1'b0, 0, 32'h1);
    step();

    // Reset mid-operation discards the issue and clears values
    rst_in = 1'b0;
    iss(3, 5);
    cm(0, 5, 0, 32'h1234);
    step();
    rst_in = 1'b1;
    rd(0, 3); rd(1, 5);
    expect_rd("x3_after_rst", 0, 1'b0, 1'b0, 0, 32'h0);
    expect_rd("x5_after_rst", 1, 1'b0, 1'b0, 0, 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
